stb_sample_ctrl: RTL and testbench
==================================

Name: stb_sample_ctrl

Overview:
Downstream consumer of the strobe generator in the measure unit. It requests strobes from the generator, waits for each valid strobe, and samples the synchronised comparator output a fixed settle time after the strobe. It counts comparator "ones" over N strobes and hands the count to the CSR/firmware side with a done pulse. It also detects an unlocked generator and lost strobes, reporting either as a timeout error.

Parameters:
CNT_WIDTH, 16, width of sample-count request and result counters
T_WIDTH, 32, width of strobe period input and timeout counter (matches generator period width)
SETTLE_CYCLES, 4, clk cycles from stb_valid_i rise to comparator sample (>=1)
TMO_MARGIN, 16, cycles added to 2*period for the per-strobe timeout

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous active-high reset
start_i  in  1  start acquisition; single-cycle pulse, ignored while busy_o=1
n_samples_i  in  CNT_WIDTH  number of strobes to sample; latched on accepted start_i
cmp_i  in  1  asynchronous comparator output; synchronised internally, 2 stages
stb_rdy_i  in  1  generator locked (generator rdy)
stb_valid_i  in  1  generator strobe-valid
stb_period_i  in  T_WIDTH  measured period in clk cycles
stb_req_o  out  1  strobe request to generator; rising edge arms the next strobe
busy_o  out  1  acquisition in progress
done_o  out  1  one-cycle pulse when results are final
err_o  out  1  sticky error; cleared by the next accepted start_i
ones_cnt_o  out  CNT_WIDTH  number of samples with comparator = 1
samples_o  out  CNT_WIDTH  number of samples actually taken

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- Synchronous FSM. The reset branch uses non-blocking assignment.
- IDLE: on start_i, do all of the following, then go to CHECK:
  - latch n_samples_i into n_req;
  - clear ones_cnt_o, samples_o and err_o;
  - latch tmo_lim = 2*stb_period_i + TMO_MARGIN, saturating at all-ones T_WIDTH.
- CHECK (one cycle):
  - if stb_rdy_i=0: err_o<=1, go to DONE;
  - else if n_req==0: go to DONE;
  - else go to REQ.
- REQ: stb_req_o=1 for exactly one cycle; clear tmo counter; go to WAIT_LOW.
- WAIT_LOW: stb_req_o=0; wait for stb_valid_i==0, i.e. the generator has accepted the request.
- WAIT_VALID: wait for stb_valid_i==1; then clear the settle counter and go to SETTLE.
- Timeout in WAIT_LOW and WAIT_VALID:
  - tmo counter increments each cycle in either state;
  - when tmo==tmo_lim: err_o<=1, go to DONE.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (one cycle):
  - samples_o += 1;
  - ones_cnt_o += cmp_sync;
  - if samples_o+1 == n_req go to DONE, else go to REQ.
- DONE: done_o=1 for one cycle; go to IDLE.
- busy_o=1 in every state except IDLE.
- Result stability: ones_cnt_o and samples_o update only in SAMPLE. They hold their values after done_o until the next accepted start_i.
- Latency:
  - start_i to first stb_req_o rise = 2 cycles;
  - stb_valid_i rise to sample = SETTLE_CYCLES+1 cycles;
  - last SAMPLE to done_o = 1 cycle.
- Boundary conditions:
  - start_i while busy: ignored, no state change.
  - stb_rdy_i drops mid-acquisition: no direct effect; missing strobes trigger the timeout.
  - stb_valid_i already 0 on entry to WAIT_LOW: leave after 1 cycle.
  - stb_valid_i glitch high in WAIT_LOW: no effect; only WAIT_VALID looks for the rise.
  - n_req = max value: counters do not wrap, because the exit test fires at equality.
  - stb_period_i changing mid-run: ignored; tmo_lim is frozen at start.
  - Reset mid-operation: FSM returns to IDLE; stb_req_o and all outputs drop to 0 immediately (asynchronous).
  - Error path: done_o still pulses. Partial counts remain readable.

Decomposition:
- Shared package measure_pkg:
  - state enum stb_sample_state_t (IDLE, CHECK, REQ, WAIT_LOW, WAIT_VALID, SETTLE, SAMPLE, DONE);
  - constant DEFAULT_SETTLE_CYCLES;
  - constant DEFAULT_TMO_MARGIN.
- Comparator synchroniser reuses existing sync_ff (WIDTH=1, STAGES=2). No other sub-module.

Test Plan:
- Generator model with period 100, rdy=1; comparator held 1; start with n_samples_i=8 -> 8 stb_req_o pulses; done_o after 8 samples; ones_cnt_o=8, samples_o=8, err_o=0.
- Comparator toggling each strobe, n_samples_i=10 -> ones_cnt_o=5, samples_o=10; each sample taken exactly SETTLE_CYCLES+1 cycles after stb_valid_i rise.
- stb_rdy_i=0 at start -> err_o=1, done_o pulses at cycle 2, samples_o=0, stb_req_o never asserted.
- Period 50; model stops producing valid after 3 strobes, n_samples_i=6 -> timeout after exactly 116 cycles in WAIT_VALID; err_o=1, samples_o=3, done_o pulses once.
- n_samples_i=0 -> done_o at cycle 2, counts 0, err_o=0; a second start_i issued while busy in another run is ignored (samples_o equals the first request).
- arst_i asserted during SETTLE of a 4-sample run -> outputs 0 asynchronously. After release, a new start with n_samples_i=2 completes normally with samples_o=2.

Source files
------------

// File: rtl/measure_pkg.sv
// Shared definitions for the measure unit: strobe-sampler FSM states and
// default timing constants.
package measure_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    WAIT_LOW,
    WAIT_VALID,
    SETTLE,
    SAMPLE,
    DONE
  } stb_sample_state_t;

  localparam int unsigned DEFAULT_SETTLE_CYCLES = 4;
  localparam int unsigned DEFAULT_TMO_MARGIN    = 16;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for asynchronous level inputs.
module sync_ff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    sync_d[0] = d_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/stb_sample_ctrl.sv
// Strobe sampler: requests strobes from the generator, samples the synchronised
// comparator a fixed settle time after each strobe, and counts the ones.
module stb_sample_ctrl
  import measure_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned T_WIDTH       = 32,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int unsigned TMO_MARGIN    = DEFAULT_TMO_MARGIN
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_samples_i,
  input  logic                 cmp_i,
  input  logic                 stb_rdy_i,
  input  logic                 stb_valid_i,
  input  logic [T_WIDTH-1:0]   stb_period_i,
  output logic                 stb_req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] ones_cnt_o,
  output logic [CNT_WIDTH-1:0] samples_o
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  stb_sample_state_t    state_q, state_d;
  logic [CNT_WIDTH-1:0] n_req_q, n_req_d;
  logic [CNT_WIDTH-1:0] ones_q, ones_d;
  logic [CNT_WIDTH-1:0] samples_q, samples_d;
  logic                 err_q, err_d;
  logic [T_WIDTH-1:0]   tmo_lim_q, tmo_lim_d;
  logic [T_WIDTH-1:0]   tmo_q, tmo_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [T_WIDTH+1:0]   tmo_sum;
  logic [CNT_WIDTH:0]   samp_next;
  logic                 cmp_sync;

  sync_ff #(
    .WIDTH  (1),
    .STAGES (2)
  ) u_cmp_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (cmp_i),
    .q_o    (cmp_sync)
  );

  always_comb begin
    // Two guard bits so 2*period + margin can saturate instead of wrapping
    tmo_sum   = {1'b0, stb_period_i, 1'b0} + (T_WIDTH+2)'(TMO_MARGIN);
    samp_next = {1'b0, samples_q} + (CNT_WIDTH+1)'(1);

    state_d   = state_q;
    n_req_d   = n_req_q;
    ones_d    = ones_q;
    samples_d = samples_q;
    err_d     = err_q;
    tmo_lim_d = tmo_lim_q;
    tmo_d     = tmo_q;
    settle_d  = settle_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_req_d   = n_samples_i;
          ones_d    = '0;
          samples_d = '0;
          err_d     = 1'b0;
          tmo_lim_d = (|tmo_sum[T_WIDTH+1:T_WIDTH]) ? '1 : tmo_sum[T_WIDTH-1:0];
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (!stb_rdy_i) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (n_req_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        tmo_d   = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW, WAIT_VALID: begin
        // One timeout budget spans both waits for a single strobe
        if (tmo_q == tmo_lim_q) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + T_WIDTH'(1);
          if (state_q == WAIT_LOW && !stb_valid_i) begin
            state_d = WAIT_VALID;
          end else if (state_q == WAIT_VALID && stb_valid_i) begin
            settle_d = '0;
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        samples_d = samp_next[CNT_WIDTH-1:0];
        ones_d    = ones_q + CNT_WIDTH'(cmp_sync);
        state_d   = (samp_next == {1'b0, n_req_q}) ? DONE : REQ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      n_req_q   <= '0;
      ones_q    <= '0;
      samples_q <= '0;
      err_q     <= 1'b0;
      tmo_lim_q <= '0;
      tmo_q     <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      n_req_q   <= n_req_d;
      ones_q    <= ones_d;
      samples_q <= samples_d;
      err_q     <= err_d;
      tmo_lim_q <= tmo_lim_d;
      tmo_q     <= tmo_d;
      settle_q  <= settle_d;
    end
  end

  assign stb_req_o  = (state_q == REQ);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;
  assign ones_cnt_o = ones_q;
  assign samples_o  = samples_q;

endmodule

// File: tb/tb_stb_sample_ctrl.sv
// Bench for stb_sample_ctrl: behavioural strobe generator, table of runs with a
// result scoreboard, plus hand-written busy-start and mid-run reset sequences.
module tb_stb_sample_ctrl;

  localparam int unsigned CW     = 16;
  localparam int unsigned TW     = 32;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned MARGIN = 16;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [CW-1:0] n_samples_i = '0;
  logic          cmp_i = 1'b0;
  logic          stb_rdy_i = 1'b1;
  logic          stb_valid_i = 1'b0;
  logic [TW-1:0] stb_period_i = '0;
  logic          stb_req_o, busy_o, done_o, err_o;
  logic [CW-1:0] ones_cnt_o, samples_o;

  stb_sample_ctrl #(
    .CNT_WIDTH     (CW),
    .T_WIDTH       (TW),
    .SETTLE_CYCLES (SETTLE),
    .TMO_MARGIN    (MARGIN)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .start_i      (start_i),
    .n_samples_i  (n_samples_i),
    .cmp_i        (cmp_i),
    .stb_rdy_i    (stb_rdy_i),
    .stb_valid_i  (stb_valid_i),
    .stb_period_i (stb_period_i),
    .stb_req_o    (stb_req_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .ones_cnt_o   (ones_cnt_o),
    .samples_o    (samples_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned n;
    bit          rdy;
    int unsigned period;
    int unsigned limit;
    bit          toggle;
    bit          cmp_val;
    int unsigned exp_ones;
    int unsigned exp_samples;
    bit          exp_err;
    int unsigned exp_reqs;
  } vec_t;

  typedef struct {
    int unsigned ones;
    int unsigned samples;
    bit          err;
  } res_t;

  res_t sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // generator / monitor state
  int unsigned cyc = 0;
  int unsigned gen_period = 10;
  int unsigned gen_limit = 1000;
  int unsigned gen_served = 0;
  int unsigned gen_cnt = 0;
  bit          gen_pending = 0;
  bit          gen_toggle = 0;
  bit          req_prev = 0;
  int unsigned req_count = 0, done_count = 0, rise_count = 0;
  int unsigned rise_cyc = 0, first_req_cyc = 0, last_req_cyc = 0, last_done_cyc = 0;
  int unsigned samp_prev = 0;
  int unsigned start_cyc = 0;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    if (arst_i) begin
      gen_pending = 0;
      req_prev    = 0;
      samp_prev   = 0;
      return;
    end
    if (done_o) begin
      done_count++;
      last_done_cyc = cyc;
    end
    if (samples_o != CW'(samp_prev)) begin
      // SAMPLE was the cycle before the counter became visible
      if (samples_o != '0) chk("sample_latency", (cyc - 1) - rise_cyc, SETTLE + 1);
      samp_prev = samples_o;
    end
    if (stb_req_o && !req_prev) begin
      req_count++;
      if (req_count == 1) first_req_cyc = cyc;
      last_req_cyc = cyc;
      stb_valid_i = 1'b0;
      if (gen_toggle) cmp_i = ~cmp_i;
      if (gen_served < gen_limit) begin
        gen_served++;
        gen_pending = 1;
        gen_cnt     = gen_period;
      end
    end else if (gen_pending) begin
      gen_cnt--;
      if (gen_cnt == 0) begin
        stb_valid_i = 1'b1;
        gen_pending = 0;
        rise_cyc    = cyc;
        rise_count++;
      end
    end
    req_prev = stb_req_o;
  endtask

  initial forever begin
    @(negedge clk_i);
    tick();
  end

  task automatic setup_run(input vec_t v);
    gen_period   = v.period;
    gen_limit    = v.limit;
    gen_served   = 0;
    gen_toggle   = v.toggle;
    cmp_i        = v.cmp_val;
    stb_rdy_i    = v.rdy;
    stb_period_i = TW'(v.period);
    req_count    = 0;
    done_count   = 0;
    rise_count   = 0;
    sb_q.push_back('{ones: v.exp_ones, samples: v.exp_samples, err: v.exp_err});
  endtask

  task automatic pulse_start(input int unsigned n);
    @(negedge clk_i);
    n_samples_i = CW'(n);
    start_i     = 1'b1;
    start_cyc   = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done_and_check(input string tag, input int unsigned exp_reqs);
    res_t exp;
    bit   seen = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done_count != 0) begin
        seen = 1;
        break;
      end
      @(negedge clk_i);
      #1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    exp = sb_q.pop_front();
    if (!seen) return;
    chk({tag, "_ones"}, ones_cnt_o, exp.ones);
    chk({tag, "_samples"}, samples_o, exp.samples);
    chk({tag, "_err"}, err_o, exp.err);
    repeat (4) @(negedge clk_i);
    #1;
    chk({tag, "_done_once"}, done_count, 1);
    chk({tag, "_reqs"}, req_count, exp_reqs);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_hold"}, samples_o, exp.samples);
  endtask

  vec_t vecs[6];

  initial begin
    //               n  rdy per  lim  tog cmp ones smp err reqs
    vecs[0] = '{8,  1, 100, 1000, 0, 1, 8, 8,  0, 8};
    vecs[1] = '{10, 1, 30,  1000, 1, 0, 5, 10, 0, 10};
    vecs[2] = '{5,  0, 100, 1000, 0, 1, 0, 0,  1, 0};
    vecs[3] = '{6,  1, 50,  3,    0, 1, 3, 3,  1, 4};
    vecs[4] = '{0,  1, 20,  1000, 0, 1, 0, 0,  0, 0};
    vecs[5] = '{3,  1, 7,   1000, 0, 0, 0, 3,  0, 3};

    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_req", stb_req_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ones", ones_cnt_o, 0);
    chk("rst_samples", samples_o, 0);
    arst_i = 1'b0;

    for (int k = 0; k < 6; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      setup_run(vecs[k]);
      pulse_start(vecs[k].n);
      wait_done_and_check(tag, vecs[k].exp_reqs);
      if (vecs[k].exp_reqs != 0)
        chk({tag, "_start_to_req"}, first_req_cyc - start_cyc, 2);
      else
        chk({tag, "_start_to_done"}, last_done_cyc - start_cyc, 2);
      if (vecs[k].limit < vecs[k].n)
        chk({tag, "_tmo_cycles"}, last_done_cyc - last_req_cyc, 2 + 2 * vecs[k].period + MARGIN);
    end

    // start while busy is ignored: only the first request is honoured
    setup_run('{3, 1, 10, 1000, 0, 1, 3, 3, 0, 3});
    pulse_start(3);
    for (int i = 0; i < 200 && req_count == 0; i++) @(negedge clk_i);
    n_samples_i = CW'(7);
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done_and_check("busy_start", 3);

    // asynchronous reset while settling on the third strobe
    setup_run('{4, 1, 20, 1000, 0, 1, 4, 4, 0, 4});
    pulse_start(4);
    for (int i = 0; i < 2000 && rise_count < 3; i++) @(negedge clk_i);
    chk("rst_mid_rise_seen", rise_count, 3);
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_mid_pre_samples", samples_o, 2);
    chk("rst_mid_pre_busy", busy_o, 1);
    arst_i = 1'b1;
    #1;
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_samples", samples_o, 0);
    chk("rst_mid_ones", ones_cnt_o, 0);
    chk("rst_mid_req", stb_req_o, 0);
    void'(sb_q.pop_back());
    @(negedge clk_i);
    arst_i = 1'b0;
    setup_run('{2, 1, 20, 1000, 0, 1, 2, 2, 0, 2});
    pulse_start(2);
    wait_done_and_check("post_rst", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
